// File: rtl/dev_bus_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// dev_bus_arbiter_pkg
//
// Purpose: shared definitions for the two-master device-bus arbiter.
//   - state encoding of the ADDR/RESP sequencer
//   - master id constants
//   - default base address of the device window
//   - address window decode helper
//
// Optional feature macro used by the files importing this package:
//   ARB_FIXED_PRIO_EN -- M0 always wins a tie, no round-robin pointer.
// ----------------------------------------------------------------------------
package dev_bus_arbiter_pkg;

    // Sequencer states: one address cycle, one response cycle, then idle.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    // Master identifiers, also used as the round-robin pointer value.
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Default first byte address of the device window.
    localparam logic [31:0] DEV_BASE_DEFAULT = 32'h0000_7F00;

    // Window decode: the address belongs to the device when its bits above
    // the span equal the base. span_mask is DEV_SPAN-1, so the low bits
    // (including the byte offset [1:0]) never take part in the compare.
    function automatic logic addr_in_window(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] span_mask
    );
        return (addr & ~span_mask) == base;
    endfunction

endpackage : dev_bus_arbiter_pkg

// File: rtl/dev_bus_arbiter_arb_rr2.sv
// ----------------------------------------------------------------------------
// arb_rr2
//
// Purpose: two-requester picker. The grant is purely combinational from the
// request vector; a last-grant pointer register breaks ties round-robin.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset (pointer -> M1)
//   req_i[1:0]   in   request vector, bit 0 = M0, bit 1 = M1
//   accept_i     in   the caller takes the current grant this cycle
//   gnt_valid_o  out  at least one requester present
//   gnt_id_o     out  id of the selected requester
//
// Macro ARB_FIXED_PRIO_EN: when defined, M0 always wins a tie and the
// pointer register is not built (M1 may starve).
// ----------------------------------------------------------------------------
module arb_rr2
    import dev_bus_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic       gnt_valid_o,
    output logic       gnt_id_o
);

`ifdef ARB_FIXED_PRIO_EN

    // Plain priority select; clock, reset and accept are not needed here.
    always_comb begin
        gnt_valid_o = |req_i;
        gnt_id_o    = req_i[0] ? M0 : M1;
    end

`else

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_valid_o = |req_i;
        gnt_id_o    = M0;
        unique case (req_i)
            2'b01:   gnt_id_o = M0;
            2'b10:   gnt_id_o = M1;
            // Tie: the master that was not granted last time wins.
            2'b11:   gnt_id_o = ~last_q;
            default: gnt_id_o = M0;
        endcase
    end

    // The pointer only moves when a tie is resolved; a lone requester
    // does not consume the other master's turn.
    always_comb begin
        last_d = last_q;
        if (accept_i && (&req_i)) begin
            last_d = gnt_id_o;
        end
    end

    // Reset to M1 so that M0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= M1;
        end else begin
            last_q <= last_d;
        end
    end

`endif

endmodule : arb_rr2

// File: rtl/dev_bus_arbiter.sv
// ----------------------------------------------------------------------------
// dev_bus_arbiter
//
// Purpose: shares the CPU-side port of the device bridge between M0 (CPU
// data port) and M1 (DMA/debug engine). Each access is serialised into one
// address cycle (ADDR) and one response cycle (RESP). Addresses outside the
// device window are not issued to the bridge and are answered with err.
//
// Parameters:
//   DEV_BASE  first byte address of the device window
//   DEV_SPAN  window size in bytes (power of two, at least 4)
//
// Ports (mX_* exist for M0 and M1):
//   clk, reset_n     clock (rising edge), asynchronous active-low reset
//   mX_req           request, held with qualifiers until mX_gnt
//   mX_we/be/addr/wd write enable, byte enables, byte address, write data
//   mX_gnt           address phase accepted (one cycle)
//   mX_done          response valid, one-cycle pulse
//   mX_err           out-of-window flag, qualified by mX_done
//   mX_rd            read data, qualified by mX_done, held otherwise
//   pr_we/be/addr/wd to the bridge PrWe/PrBE/PrAddr/PrWD
//   pr_rd            from the bridge PrRD, valid in the cycle of pr_addr
//
// Macro ARB_FIXED_PRIO_EN: fixed priority (M0 wins ties) instead of
// round-robin. Latency and error handling are unchanged.
// ----------------------------------------------------------------------------
module dev_bus_arbiter
    import dev_bus_arbiter_pkg::*;
#(
    parameter logic [31:0] DEV_BASE = DEV_BASE_DEFAULT,
    parameter int          DEV_SPAN = 32
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [3:0]  m0_be,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wd,
    output logic        m0_gnt,
    output logic        m0_done,
    output logic        m0_err,
    output logic [31:0] m0_rd,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [3:0]  m1_be,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wd,
    output logic        m1_gnt,
    output logic        m1_done,
    output logic        m1_err,
    output logic [31:0] m1_rd,

    output logic        pr_we,
    output logic [3:0]  pr_be,
    output logic [31:0] pr_addr,
    output logic [31:0] pr_wd,
    input  logic [31:0] pr_rd
);

    localparam logic [31:0] SPAN_MASK = 32'(DEV_SPAN - 1);

    // ------------------------------------------------------------------
    // State and latched transaction
    // ------------------------------------------------------------------
    arb_state_e  state_q,  state_d;
    logic        id_q,     id_d;
    logic        we_q,     we_d;
    logic [3:0]  be_q,     be_d;
    logic [31:0] addr_q,   addr_d;
    logic [31:0] wd_q,     wd_d;
    logic        err_q,    err_d;
    logic [31:0] m0_rd_q,  m0_rd_d;
    logic [31:0] m1_rd_q,  m1_rd_d;

    logic        in_window;
    logic        arb_valid;
    logic        arb_id;
    logic        arb_accept;

    assign in_window = addr_in_window(addr_q, DEV_BASE, SPAN_MASK);

    // ------------------------------------------------------------------
    // Requester selection
    // ------------------------------------------------------------------
    arb_rr2 u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_i       ({m1_req, m0_req}),
        .accept_i    (arb_accept),
        .gnt_valid_o (arb_valid),
        .gnt_id_o    (arb_id)
    );

    // ------------------------------------------------------------------
    // Next-state logic. Requests are only looked at in IDLE, so a request
    // raised and dropped while ADDR/RESP is busy leaves no trace.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wd_d       = wd_q;
        err_d      = err_q;
        m0_rd_d    = m0_rd_q;
        m1_rd_d    = m1_rd_q;
        arb_accept = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    arb_accept = 1'b1;
                    id_d       = arb_id;
                    err_d      = 1'b0;
                    if (arb_id == M1) begin
                        we_d   = m1_we;
                        be_d   = m1_be;
                        addr_d = m1_addr;
                        wd_d   = m1_wd;
                    end else begin
                        we_d   = m0_we;
                        be_d   = m0_be;
                        addr_d = m0_addr;
                        wd_d   = m0_wd;
                    end
                    state_d = ST_ADDR;
                end
            end

            ST_ADDR: begin
                // The bridge answers combinationally; capture its read
                // data into the granted master's register only, so the
                // other master's last read value is preserved.
                err_d = ~in_window;
                if (id_q == M1) begin
                    m1_rd_d = pr_rd;
                end else begin
                    m0_rd_d = pr_rd;
                end
                state_d = ST_RESP;
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            id_q    <= M0;
            we_q    <= 1'b0;
            be_q    <= 4'h0;
            addr_q  <= 32'h0;
            wd_q    <= 32'h0;
            err_q   <= 1'b0;
            m0_rd_q <= 32'h0;
            m1_rd_q <= 32'h0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            m0_rd_q <= m0_rd_d;
            m1_rd_q <= m1_rd_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. The bridge strobes are decoded from state rather than
    // registered, so an asynchronous reset during ADDR drops pr_we at once
    // and the pending write never reaches the device.
    // ------------------------------------------------------------------
    always_comb begin
        pr_addr = addr_q;
        pr_wd   = wd_q;
        pr_we   = 1'b0;
        pr_be   = 4'h0;
        if (state_q == ST_ADDR && in_window) begin
            pr_we = we_q;
            pr_be = be_q;
        end
    end

    assign m0_gnt  = (state_q == ST_ADDR) && (id_q == M0);
    assign m1_gnt  = (state_q == ST_ADDR) && (id_q == M1);
    assign m0_done = (state_q == ST_RESP) && (id_q == M0);
    assign m1_done = (state_q == ST_RESP) && (id_q == M1);
    assign m0_err  = m0_done & err_q;
    assign m1_err  = m1_done & err_q;
    assign m0_rd   = m0_rd_q;
    assign m1_rd   = m1_rd_q;

endmodule : dev_bus_arbiter

// File: tb/tb_dev_bus_arbiter.sv
module tb_dev_bus_arbiter;
    import dev_bus_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m0_req, m0_we;
    logic [3:0]  m0_be;
    logic [31:0] m0_addr, m0_wd;
    logic        m0_gnt, m0_done, m0_err;
    logic [31:0] m0_rd;
    logic        m1_req, m1_we;
    logic [3:0]  m1_be;
    logic [31:0] m1_addr, m1_wd;
    logic        m1_gnt, m1_done, m1_err;
    logic [31:0] m1_rd;
    logic        pr_we;
    logic [3:0]  pr_be;
    logic [31:0] pr_addr, pr_wd, pr_rd;

    // Bridge model: either a constant read value or an address-derived one.
    logic        bridge_mode;
    logic [31:0] rd_const;
    assign pr_rd = bridge_mode ? {16'hA5A5, pr_addr[15:0]} : rd_const;

    always #5 clk = ~clk;

    dev_bus_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wd(m0_wd),
        .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_err(m0_err), .m0_rd(m0_rd),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wd(m1_wd),
        .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_err(m1_err), .m1_rd(m1_rd),
        .pr_we(pr_we), .pr_be(pr_be), .pr_addr(pr_addr), .pr_wd(pr_wd), .pr_rd(pr_rd)
    );

    typedef struct {
        logic        id;
        logic        err;
        logic [31:0] rd;
    } resp_t;

    resp_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    // Response scoreboard: every done pulse is matched against the oldest
    // expected response.
    always @(negedge clk) begin
        resp_t       e;
        logic [31:0] got_rd;
        logic        got_err;
        if (reset_n && (m0_done || m1_done)) begin
            vectors++;
            got_rd  = m1_done ? m1_rd  : m0_rd;
            got_err = m1_done ? m1_err : m0_err;
            if (m0_done && m1_done) begin
                miscompares++;
                $display("FAIL resp_both_done: m0_done=1 m1_done=1, required only one");
            end else if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL resp_unexpected: done from M%0d with none expected", m1_done);
            end else begin
                e = exp_q.pop_front();
                if ({m1_done, got_err, got_rd} !== {e.id, e.err, e.rd}) begin
                    miscompares++;
                    $display("FAIL resp: got id=%0d err=%0d rd=%h, required id=%0d err=%0d rd=%h",
                             m1_done, got_err, got_rd, e.id, e.err, e.rd);
                end else begin
                    $display("resp M%0d err=%0d rd=%h ok", e.id, e.err, e.rd);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_be = 0; m0_addr = 0; m0_wd = 0;
        m1_req = 0; m1_we = 0; m1_be = 0; m1_addr = 0; m1_wd = 0;
        bridge_mode = 1'b0; rd_const = 32'h0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err, pr_we} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b, required 0000000",
                     {m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err, pr_we});
        end
        vectors++;
        if ({m0_rd, m1_rd, pr_be, pr_addr, pr_wd} !== 132'b0) begin
            miscompares++;
            $display("FAIL reset_data: m0_rd=%h m1_rd=%h pr_be=%h pr_addr=%h pr_wd=%h, required 0",
                     m0_rd, m1_rd, pr_be, pr_addr, pr_wd);
        end
        $display("reset state checked");
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_m0_read();
        bridge_mode = 1'b0; rd_const = 32'hDEADBEEF;
        m0_we = 0; m0_be = 4'hF; m0_addr = 32'h0000_7F04; m0_wd = 32'h0;
        exp_q.push_back('{M0, 1'b0, 32'hDEADBEEF});
        m0_req = 1'b1;
        @(negedge clk);
        vectors++;
        if ({m0_gnt, m1_gnt, pr_we, m0_done} !== 4'b1000 || pr_addr !== 32'h7F04) begin
            miscompares++;
            $display("FAIL m0_read_addr: gnt0=%b gnt1=%b pr_we=%b done=%b pr_addr=%h, required 1 0 0 0 00007f04",
                     m0_gnt, m1_gnt, pr_we, m0_done, pr_addr);
        end
        m0_req = 1'b0;
        @(negedge clk);
        vectors++;
        if ({m0_done, m0_gnt, pr_we} !== 3'b100) begin
            miscompares++;
            $display("FAIL m0_read_resp: done=%b gnt=%b pr_we=%b, required 1 0 0", m0_done, m0_gnt, pr_we);
        end
        @(negedge clk);
        vectors++;
        if (m0_done !== 1'b0 || m0_rd !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL m0_rd_hold: done=%b rd=%h, required 0 deadbeef", m0_done, m0_rd);
        end
        $display("m0 read 7f04 done");
    endtask

    task automatic test_m1_write();
        rd_const = 32'h0BADF00D;
        m1_we = 1; m1_be = 4'b0011; m1_addr = 32'h0000_7F10; m1_wd = 32'h12345678;
        exp_q.push_back('{M1, 1'b0, 32'h0BADF00D});
        m1_req = 1'b1;
        @(negedge clk);
        vectors++;
        if ({m1_gnt, pr_we, pr_be} !== 6'b1_1_0011 || pr_addr !== 32'h7F10 || pr_wd !== 32'h12345678) begin
            miscompares++;
            $display("FAIL m1_write_addr: gnt=%b we=%b be=%b addr=%h wd=%h, required 1 1 0011 00007f10 12345678",
                     m1_gnt, pr_we, pr_be, pr_addr, pr_wd);
        end
        m1_req = 1'b0;
        @(negedge clk);
        vectors++;
        if ({m1_done, pr_we} !== 2'b10 || m0_rd !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL m1_write_resp: done=%b pr_we=%b m0_rd=%h, required 1 0 deadbeef",
                     m1_done, pr_we, m0_rd);
        end
        @(negedge clk);
        $display("m1 write 7f10 done");
    endtask

    task automatic test_back_to_back();
        int    waited;
        logic  exp_id;
        logic  got_id;
        bridge_mode = 1'b1;
        m0_we = 0; m0_be = 4'hF; m0_addr = 32'h0000_7F08;
        m1_we = 0; m1_be = 4'hF; m1_addr = 32'h0000_7F0C;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!(m0_gnt || m1_gnt) && waited < 8);
            vectors++;
            if (!(m0_gnt || m1_gnt) || (m0_gnt && m1_gnt)) begin
                miscompares++;
                $display("FAIL b2b_grant%0d: gnt0=%b gnt1=%b, required exactly one", k, m0_gnt, m1_gnt);
                break;
            end
`ifdef ARB_FIXED_PRIO_EN
            exp_id = M0;
`else
            exp_id = (k % 2 == 0) ? M0 : M1;
`endif
            got_id = m1_gnt;
            exp_q.push_back('{exp_id, 1'b0,
                              {16'hA5A5, (exp_id == M1) ? 16'h7F0C : 16'h7F08}});
            if (got_id !== exp_id) begin
                miscompares++;
                $display("FAIL b2b_order%0d: granted M%0d, required M%0d", k, got_id, exp_id);
            end else begin
                $display("b2b grant %0d to M%0d", k, got_id);
            end
            if (k > 0) begin
                vectors++;
                if (waited !== 3) begin
                    miscompares++;
                    $display("FAIL b2b_spacing%0d: %0d cycles between grants, required 3", k, waited);
                end
            end
            if (k == 5) begin
                m0_req = 1'b0; m1_req = 1'b0;
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (2) @(negedge clk);
        bridge_mode = 1'b0;
    endtask

    task automatic test_out_of_window();
        rd_const = 32'h55AA55AA;
        m0_we = 1; m0_be = 4'hF; m0_addr = 32'h0000_2000; m0_wd = 32'h1111_2222;
        exp_q.push_back('{M0, 1'b1, 32'h55AA55AA});
        m0_req = 1'b1;
        @(negedge clk);
        vectors++;
        if ({m0_gnt, pr_we, pr_be} !== 6'b1_0_0000) begin
            miscompares++;
            $display("FAIL oow_addr: gnt=%b pr_we=%b pr_be=%b, required 1 0 0000", m0_gnt, pr_we, pr_be);
        end
        m0_req = 1'b0;
        @(negedge clk);
        vectors++;
        if ({m0_done, m0_err, pr_we} !== 3'b110) begin
            miscompares++;
            $display("FAIL oow_resp: done=%b err=%b pr_we=%b, required 1 1 0", m0_done, m0_err, pr_we);
        end
        @(negedge clk);
        $display("m0 write 2000 out of window done");
    endtask

    task automatic test_reset_in_addr();
        rd_const = 32'h7777_0000;
        m1_we = 1; m1_be = 4'hF; m1_addr = 32'h0000_7F14; m1_wd = 32'hCAFE_F00D;
        m1_req = 1'b1;
        @(negedge clk);
        vectors++;
        if ({m1_gnt, pr_we} !== 2'b11) begin
            miscompares++;
            $display("FAIL rst_addr_pre: gnt=%b pr_we=%b, required 1 1", m1_gnt, pr_we);
        end
        #1 reset_n = 1'b0;
        #1;
        vectors++;
        if ({pr_we, m1_gnt} !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_addr_we: pr_we=%b gnt=%b, required 0 0", pr_we, m1_gnt);
        end
        m1_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({m1_done, m1_gnt, m0_gnt} !== 3'b000) begin
                miscompares++;
                $display("FAIL rst_no_done%0d: m1_done=%b m1_gnt=%b m0_gnt=%b, required 0 0 0",
                         i, m1_done, m1_gnt, m0_gnt);
            end
        end
        vectors++;
        if (m0_rd !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_rd_clear: m0_rd=%h, required 00000000", m0_rd);
        end
        m0_we = 0; m0_addr = 32'h0000_7F00; m1_we = 0;
        exp_q.push_back('{M0, 1'b0, 32'h7777_0000});
        m0_req = 1'b1; m1_req = 1'b1;
        @(negedge clk);
        vectors++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            miscompares++;
            $display("FAIL rst_first_tie: gnt0=%b gnt1=%b, required 1 0", m0_gnt, m1_gnt);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        repeat (2) @(negedge clk);
        $display("reset during m1 write addr phase done");
    endtask

    task automatic test_drop_in_resp();
        rd_const = 32'h3C3C_3C3C;
        m1_we = 0; m1_addr = 32'h0000_7F18;
        exp_q.push_back('{M1, 1'b0, 32'h3C3C_3C3C});
        m1_req = 1'b1;
        @(negedge clk);
        vectors++;
        if (m1_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_m1_gnt: gnt=%b, required 1", m1_gnt);
        end
        m1_req = 1'b0;
        @(negedge clk);
        m0_we = 1; m0_addr = 32'h0000_7F00; m0_be = 4'hF;
        m0_req = 1'b1;
        vectors++;
        if (m1_done !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_m1_done: done=%b, required 1", m1_done);
        end
        @(negedge clk);
        m0_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({m0_gnt, m1_gnt, pr_we, m0_done} !== 4'b0000) begin
                miscompares++;
                $display("FAIL drop_idle%0d: gnt0=%b gnt1=%b pr_we=%b done0=%b, required 0 0 0 0",
                         i, m0_gnt, m1_gnt, pr_we, m0_done);
            end
        end
        $display("m0 request during m1 resp withdrawn");
    endtask

    initial begin
        test_reset();
        test_m0_read();
        test_m1_write();
        test_back_to_back();
        test_out_of_window();
        test_reset_in_addr();
        test_drop_in_resp();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_resp: %0d expected responses never arrived, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_dev_bus_arbiter

// File: doc/dev_bus_arbiter.md
Name: dev_bus_arbiter

Overview:
- Shares the single CPU-side port of the device bridge between two masters: M0 (CPU data port) and M1 (DMA/debug engine).
- Serialises their accesses into address and response phases, arbitrates round-robin, and flags out-of-window addresses as errors.
- Sits between the masters and the bridge's PrWe/PrBE/PrAddr/PrWD/PrRD port.

Parameters:
- DEV_BASE, 32'h0000_7F00, first byte address of the device window.
- DEV_SPAN, 32, window size in bytes; must be a power of two and at least 4.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous reset, active-low
- m0_req  in  1  M0 request; held with its qualifiers until m0_gnt
- m0_we  in  1  M0 write enable
- m0_be  in  4  M0 byte enables
- m0_addr  in  32  M0 byte address
- m0_wd  in  32  M0 write data
- m0_gnt  out  1  M0 address phase accepted
- m0_done  out  1  M0 response valid, one-cycle pulse
- m0_err  out  1  M0 address out of window, qualified by m0_done
- m0_rd  out  32  M0 read data, qualified by m0_done
- m1_*  same set as m0_*, for M1
- pr_we  out  1  to bridge PrWe
- pr_be  out  4  to bridge PrBE
- pr_addr  out  32  to bridge PrAddr
- pr_wd  out  32  to bridge PrWD
- pr_rd  in  32  from bridge PrRD; valid in the same cycle as pr_addr

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. While reset_n=0:
  - state=IDLE
  - all gnt/done/err = 0, all rd = 0
  - pr_we = 0, pr_be = 0, pr_addr = 0, pr_wd = 0
  - last-grant pointer = M1, so M0 wins the first tie.
- State machine: IDLE -> ADDR -> RESP -> IDLE.
  - IDLE:
    - No req: stay in IDLE.
    - Exactly one req: latch that master's we/be/addr/wd and its id, then go to ADDR.
    - Both req: pick the master not equal to the last-grant pointer, latch it, update the pointer, go to ADDR.
  - ADDR (one cycle):
    - The granted master's gnt=1.
    - pr_* are driven from the latched copy.
    - pr_we = latched we AND in_window.
    - If the address is out of window: pr_be=0, pr_we=0, and the error bit is set.
    - The clock edge ending ADDR performs the device write and captures pr_rd into the rd register.
    - Go to RESP.
  - RESP (one cycle):
    - The granted master's done=1, err=error bit, rd=captured data.
    - pr_we=0; pr_addr holds its value.
    - Go to IDLE.
- in_window = (addr & ~(DEV_SPAN-1)) == DEV_BASE. Address bits [1:0] are passed through unchanged.
- Latency: request sampled at edge N; gnt high in cycle N+1; done high in cycle N+2. Maximum throughput is one transaction per 3 cycles.
- rd retains its last value outside done, and it is per master: the other master's rd is untouched.
- The arbiter does not inspect req in ADDR or RESP. A request is only considered in IDLE.
- A requester dropping req before grant: its transaction is withdrawn with no side effect.
- A requester dropping req while in ADDR: its transaction completes anyway.
- Fairness: with both masters continuously requesting, grants strictly alternate. Neither master waits more than 3 cycles beyond the other's transaction.
- Reset in ADDR: pr_we falls immediately and the write is lost. No done is produced after reset.
- Write with be=0: issued as-is. The bridge masks all bytes.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
  - Defined: M0 always wins a tie. The last-grant pointer is not implemented, and M1 may starve.
  - Undefined: round-robin as described above.
- Latency and error behaviour are identical in both cases.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, ADDR=2'd1, RESP=2'd2)
  - master id constants (M0=1'b0, M1=1'b1)
  - DEV_BASE default value.
- One sub-module is natural: arb_rr2, a two-requester round-robin picker with a pointer register. It is combinational grant plus a pointer update on accept; under ARB_FIXED_PRIO_EN it reduces to a priority select.

Test Plan:
- M0 read at 0x7F04, pr_rd=32'hDEADBEEF -> m0_gnt in cycle 2; m0_done=1, m0_rd=32'hDEADBEEF, m0_err=0 in cycle 3; pr_we=0 throughout.
- M1 write at 0x7F10, be=4'b0011, wd=32'h12345678 -> pr_we=1, pr_be=4'b0011, pr_addr=0x7F10 for exactly one cycle; m1_done one cycle later.
- Both masters requesting every cycle for 6 transactions -> grant order M0,M1,M0,M1,M0,M1. With ARB_FIXED_PRIO_EN -> M0 only.
- M0 write at 0x0000_2000 -> pr_we=0, pr_be=0; m0_done=1 with m0_err=1.
- reset_n pulled low during ADDR of an M1 write -> pr_we=0 immediately; no m1_done; after release the next M0/M1 tie is granted to M0.
- M0 raises req for one cycle while state=RESP of an M1 transaction, then drops it -> no M0 grant occurs, and the bus stays idle.
